instr_issuer: RTL and testbench
===============================

Name: instr_issuer

Overview:
- Host-side sequencer that drives the CPU core's command interface: opcode, oprand1..3, addr, data, wl and rdl.
- The host pushes command entries into an internal FIFO. Each entry is an instruction, an SRAM write, an SRAM read or a HALT.
- The FSM pops entries and presents each one to the core for exactly one clock, with a programmable idle gap between entries.
- SRAM read data returned by the core is captured and handed back to the host with a valid strobe.

Parameters:
- DEPTH, 8, command FIFO entries (power of 2, ≥2).
- ISSUE_GAP, 0, extra idle cycles inserted after every issued entry.
- NOP_OPCODE, 32'h0, opcode driven when idle; must match no core opcode.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  host command valid.
- in_ready  out  1  FIFO not full.
- in_kind  in  2  0=INSTR, 1=MEMWR, 2=MEMRD, 3=HALT.
- in_w0..in_w3  in  32 each  payload words.
- go  in  1  start/resume pulse.
- busy  out  1  FSM not in IDLE/HALTED.
- halted  out  1  HALT entry consumed.
- opcode, oprand1, oprand2, oprand3  out  32 each  to core.
- addr, data  out  32 each  to core SRAM port.
- wl, rdl  out  1 each  to core write/read strobes.
- din  in  32  core dout.
- rd_valid  out  1  read data strobe.
- rd_data  out  32  captured read data.
- issue_count  out  32  entries issued (see Optional Feature).

Behaviour:
- Reset values:
  - Core outputs idle: opcode=NOP_OPCODE, oprand*/addr/data=0, wl=0, rdl=0.
  - in_ready=1, busy=0, halted=0, rd_valid=0, rd_data=0, issue_count=0.
  - FIFO empty, FSM in IDLE.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready = !full; a push while full is impossible by handshake.
  - Push and pop in the same cycle are legal.
  - No bypass: an entry pushed into an empty FIFO becomes poppable the next cycle.
  - Pointers wrap modulo DEPTH.
- All core-side outputs are registered. In every cycle with no issue, the idle values above are driven.
- FSM states: IDLE, RUN, GAP, RD_WAIT, RD_CAP, HALTED.
  - IDLE: go → RUN. Entries may be queued while in IDLE.
  - RUN, FIFO empty: drive idle, stay in RUN.
  - RUN, FIFO non-empty: pop and issue for one cycle:
    - INSTR: opcode=w0, oprand1=w1, oprand2=w2, oprand3=w3, wl=0, rdl=0.
    - MEMWR: addr=w0, data=w1, wl=1, rdl=0, opcode=NOP.
    - MEMRD: addr=w0, rdl=1, wl=0, opcode=NOP → RD_WAIT.
    - HALT: nothing driven → HALTED, halted=1.
    - Non-read entries → GAP if ISSUE_GAP>0, else stay in RUN (back-to-back issue possible).
  - GAP: counts ISSUE_GAP idle cycles, then → RUN.
  - RD_WAIT: one idle cycle while the core registers dout.
  - RD_CAP: sample din. rd_valid=1 for one cycle, rd_data=din. Then → GAP/RUN as above.
  - Read timing: rdl high in cycle T, din sampled at end of T+1, rd_valid high in T+2.
  - HALTED: outputs idle. go → RUN, and remaining FIFO entries continue. halted clears on the go cycle.
- busy = 1 in RUN, GAP, RD_WAIT and RD_CAP.
- go outside IDLE/HALTED is ignored.
- wl and rdl are never high together.
- Asynchronous reset mid-operation: all outputs return to reset values immediately and the FIFO is flushed. A pending read is lost; no rd_valid is emitted.

Optional Feature:
- Macro ISSUER_PERF_EN.
- Defined: issue_count increments by 1 for every INSTR, MEMWR or MEMRD issued. HALT is not counted. Saturates at 32'hFFFF_FFFF.
- Undefined: issue_count is tied to 0 and no counter flops are generated.

Decomposition:
- Shared package (issuer_pkg):
  - kind encodings KIND_INSTR/MEMWR/MEMRD/HALT.
  - FSM state enum.
  - command entry struct {kind, w0..w3} (130 bits).
  - NOP opcode constant.
- One natural sub-module: cmd_fifo, a synchronous FIFO parameterised by DEPTH and width, with full/empty flags.

Test Plan:
- Push INSTR {32'h0E3A, 1, 5, 0}, pulse go → one cycle later opcode=32'h0E3A, oprand1=1, oprand2=5 for exactly one cycle, wl=rdl=0, then opcode returns to 0.
- Push MEMWR {addr=4, data=32'hDEAD_BEEF} then MEMRD {addr=4}, go; bench models the core SRAM with registered dout → rd_valid pulses once with rd_data=32'hDEAD_BEEF, two cycles after rdl.
- ISSUE_GAP=2, push 3 INSTRs, go → issues spaced exactly 3 cycles apart; busy=1 throughout.
- Push DEPTH entries with no go → in_ready=0 after the 8th; a 9th in_valid is not accepted and the FIFO content is unchanged.
- Push INSTR, HALT, INSTR, go → first INSTR issued, halted=1, second INSTR held. Pulse go → second INSTR issued, halted=0.
- Deassert rst_n during RD_WAIT → rdl=wl=0, no rd_valid, in_ready=1. With ISSUER_PERF_EN defined, issue_count=0.

Source files
------------

// File: rtl/instr_issuer_pkg.sv
// issuer_pkg: shared kind encodings, FSM states and entry/core-port structs for instr_issuer.
package issuer_pkg;
  typedef enum logic [1:0] {KIND_INSTR, KIND_MEMWR, KIND_MEMRD, KIND_HALT} kind_e;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_RD_WAIT, S_RD_CAP, S_HALTED} state_e;
  typedef struct packed {
    kind_e       kind;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
  } cmd_t;
  typedef struct packed {
    logic [31:0] opcode;
    logic [31:0] oprand1;
    logic [31:0] oprand2;
    logic [31:0] oprand3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wl;
    logic        rdl;
  } core_t;
  localparam logic [31:0] NOP_OPCODE_DEF = 32'h0;
endpackage

// File: rtl/instr_issuer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO with full/empty flags; no bypass, head read straight from storage.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i) rd_q <= rd_q + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/instr_issuer.sv
// instr_issuer: FIFO-fed sequencer driving the core command/SRAM port, one cycle per entry.
// Optional issue counter enabled by defining ISSUER_PERF_EN.
module instr_issuer
  import issuer_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter int          ISSUE_GAP  = 0,
  parameter logic [31:0] NOP_OPCODE = NOP_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [31:0] in_w0,
  input  logic [31:0] in_w1,
  input  logic [31:0] in_w2,
  input  logic [31:0] in_w3,
  input  logic        go,
  output logic        busy,
  output logic        halted,
  output logic [31:0] opcode,
  output logic [31:0] oprand1,
  output logic [31:0] oprand2,
  output logic [31:0] oprand3,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        wl,
  output logic        rdl,
  input  logic [31:0] din,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [31:0] issue_count
);
  localparam core_t  IDLE_C = '{NOP_OPCODE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
  localparam state_e S_NEXT = (ISSUE_GAP > 0) ? S_GAP : S_RUN;
  state_e      state_q, state_d;
  core_t       core_q, core_d;
  logic [31:0] gap_q, gap_d, rdd_q, rdd_d;
  logic        rdv_q, rdv_d, full, empty, pop;
  cmd_t        head;
  cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid && in_ready),
    .din_i   (cmd_t'({in_kind, in_w0, in_w1, in_w2, in_w3})),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign pop      = (state_q == S_RUN) && !empty;
  assign in_ready = !full;
  assign busy     = state_q inside {S_RUN, S_GAP, S_RD_WAIT, S_RD_CAP};
  assign halted   = state_q == S_HALTED;
  assign {opcode, oprand1, oprand2, oprand3, addr, data, wl, rdl} = core_q;
  assign rd_valid = rdv_q;
  assign rd_data  = rdd_q;
  always_comb begin
    state_d = state_q;
    core_d  = IDLE_C;
    gap_d   = '0;
    rdv_d   = 1'b0;
    rdd_d   = rdd_q;
    case (state_q)
      S_IDLE, S_HALTED: state_d = go ? S_RUN : state_q;
      S_RUN:
        if (!empty)
          case (head.kind)
            KIND_INSTR: begin
              core_d  = '{head.w0, head.w1, head.w2, head.w3, 32'h0, 32'h0, 1'b0, 1'b0};
              state_d = S_NEXT;
            end
            KIND_MEMWR: begin
              core_d  = '{NOP_OPCODE, 32'h0, 32'h0, 32'h0, head.w0, head.w1, 1'b1, 1'b0};
              state_d = S_NEXT;
            end
            KIND_MEMRD: begin
              core_d  = '{NOP_OPCODE, 32'h0, 32'h0, 32'h0, head.w0, 32'h0, 1'b0, 1'b1};
              state_d = S_RD_WAIT;
            end
            default: state_d = S_HALTED;
          endcase
      S_GAP: begin
        gap_d   = gap_q + 32'd1;
        state_d = (gap_q == 32'(ISSUE_GAP - 1)) ? S_RUN : S_GAP;
      end
      S_RD_WAIT: state_d = S_RD_CAP;
      S_RD_CAP: begin
        rdv_d   = 1'b1;
        rdd_d   = din;
        state_d = S_NEXT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      core_q  <= IDLE_C;
      gap_q   <= '0;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      gap_q   <= gap_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
    end
`ifdef ISSUER_PERF_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (pop && head.kind != KIND_HALT && cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
  assign issue_count = cnt_q;
`else
  assign issue_count = '0;
`endif
endmodule

// File: tb/tb_instr_issuer.sv
// tb_instr_issuer: randomized scoreboard bench with a core SRAM model and an in-order reference queue.
module tb_instr_issuer;
  import issuer_pkg::*;
  localparam int GAP = 2;
  logic        clk = 0, rst_n = 0, in_valid = 0, go = 0;
  logic [1:0]  in_kind = 0;
  logic [31:0] in_w0 = 0, in_w1 = 0, in_w2 = 0, in_w3 = 0, din = 0;
  logic        in_ready, busy, halted, wl, rdl, rd_valid;
  logic [31:0] opcode, oprand1, oprand2, oprand3, addr, data, rd_data, issue_count;
  always #5 clk = ~clk;
  instr_issuer #(.DEPTH(8), .ISSUE_GAP(GAP), .NOP_OPCODE(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_w0(in_w0), .in_w1(in_w1), .in_w2(in_w2), .in_w3(in_w3), .go(go), .busy(busy),
    .halted(halted), .opcode(opcode), .oprand1(oprand1), .oprand2(oprand2), .oprand3(oprand3),
    .addr(addr), .data(data), .wl(wl), .rdl(rdl), .din(din), .rd_valid(rd_valid),
    .rd_data(rd_data), .issue_count(issue_count)
  );
  typedef struct {logic [1:0] k; logic [31:0] w0, w1, w2, w3;} ent_t;
  ent_t        sb[$];
  logic [31:0] rdq[$];
  int          rd_cyc[$], iss_cyc[$];
  int          cyc = 0, n_vec = 0, n_err = 0, model_cnt = 0;
  bit          autogo = 0, halted_prev = 0;
  logic [31:0] sram [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  // Core SRAM: writes land at the strobe edge, reads come back one cycle later.
  always @(posedge clk) begin
    cyc++;
    if (wl) sram[addr] = data;
    if (rdl) din <= sram.exists(addr) ? sram[addr] : 32'h0;
  end
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  function automatic logic [193:0] expv(input ent_t e);
    case (e.k)
      KIND_INSTR: return {e.w0, e.w1, e.w2, e.w3, 32'h0, 32'h0, 2'b00};
      KIND_MEMWR: return {128'h0, e.w0, e.w1, 2'b10};
      KIND_MEMRD: return {128'h0, e.w0, 32'h0, 2'b01};
      default:    return '0;
    endcase
  endfunction
  always @(negedge clk) begin
    logic [193:0] act;
    ent_t e;
    act = {opcode, oprand1, oprand2, oprand3, addr, data, wl, rdl};
    if (!rst_n) halted_prev = 0;
    else begin
      if (act != '0) begin
        chk("wl_rdl_excl", wl & rdl, 0);
        if (sb.size() == 0) chk("extra_issue", act, 0);
        else begin
          e = sb.pop_front();
          chk("issue", act, expv(e));
          iss_cyc.push_back(cyc);
          if (rdl) rd_cyc.push_back(cyc);
          if (e.k != KIND_HALT) model_cnt++;
`ifdef ISSUER_PERF_EN
          chk("issue_count", issue_count, model_cnt);
`else
          chk("issue_count", issue_count, 0);
`endif
        end
      end
      if (halted && !halted_prev) begin
        if (sb.size() == 0) chk("extra_halt", halted, 0);
        else begin
          e = sb.pop_front();
          chk("halt_order", e.k, KIND_HALT);
        end
      end
      halted_prev = halted;
      if (rd_valid) begin
        if (rdq.size() == 0 || rd_cyc.size() == 0) chk("extra_rd_valid", rd_valid, 0);
        else begin
          chk("rd_data", rd_data, rdq.pop_front());
          chk("rd_latency", cyc, rd_cyc.pop_front() + 2);
        end
      end
    end
  end
  task automatic push(input logic [1:0] k, input logic [31:0] a, b, c, d);
    bit ok = 0;
    ent_t e = '{k, a, b, c, d};
    sb.push_back(e);
    if (k == KIND_MEMWR) ref_mem[a] = b;
    if (k == KIND_MEMRD) rdq.push_back(ref_mem.exists(a) ? ref_mem[a] : 32'h0);
    {in_valid, in_kind, in_w0, in_w1, in_w2, in_w3} = {1'b1, k, a, b, c, d};
    for (int i = 0; i < 500; i++) begin
      ok = in_ready;
      go = autogo && halted;
      @(negedge clk);
      if (ok) break;
    end
    in_valid = 0;
    go = 0;
    if (!ok) chk("push_timeout", ok, 1);
  endtask
  task automatic gop();
    go = 1;
    @(negedge clk);
    go = 0;
  endtask
  task automatic drain(input bit ag);
    for (int i = 0; i < 3000 && (sb.size() != 0 || rdq.size() != 0); i++) begin
      go = ag && halted;
      @(negedge clk);
    end
    go = 0;
    if (sb.size() != 0 || rdq.size() != 0) chk("drain_timeout", sb.size() + rdq.size(), 0);
    repeat (4) @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 0;
    sb.delete();
    rdq.delete();
    rd_cyc.delete();
    iss_cyc.delete();
    model_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_core", {opcode, oprand1, oprand2, oprand3, addr, data, wl, rdl}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rd", {rd_valid, rd_data}, 0);
    chk("rst_issue_count", issue_count, 0);
    rst_n = 1;
    @(negedge clk);
    push(KIND_INSTR, 32'h0E3A, 1, 5, 0);
    repeat (3) @(negedge clk);
    chk("idle_no_issue", sb.size(), 1);
    gop();
    drain(0);
    push(KIND_MEMWR, 4, 32'hDEAD_BEEF, 0, 0);
    push(KIND_MEMRD, 4, 0, 0, 0);
    drain(0);
    do_reset();
    for (int i = 0; i < 3; i++) push(KIND_INSTR, 32'h100 + i, i, 0, 0);
    gop();
    for (int i = 0; i < 60 && iss_cyc.size() < 3; i++) begin
      chk("busy_gap", busy, 1);
      @(negedge clk);
    end
    if (iss_cyc.size() < 3) chk("gap_issue_timeout", iss_cyc.size(), 3);
    else begin
      chk("gap_spacing0", iss_cyc[1] - iss_cyc[0], GAP + 1);
      chk("gap_spacing1", iss_cyc[2] - iss_cyc[1], GAP + 1);
    end
    drain(0);
    do_reset();
    for (int i = 0; i < 8; i++) push(KIND_INSTR, 32'h200 + i, $urandom, $urandom, $urandom);
    chk("full_ready", in_ready, 0);
    {in_valid, in_kind, in_w0} = {1'b1, KIND_INSTR, 32'hBAD0_0BAD};
    @(negedge clk);
    in_valid = 0;
    chk("full_ready_hold", in_ready, 0);
    gop();
    drain(0);
    push(KIND_INSTR, 32'h300, 7, 0, 0);
    push(KIND_HALT, 0, 0, 0, 0);
    push(KIND_INSTR, 32'h301, 8, 0, 0);
    for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
    chk("halted_set", halted, 1);
    repeat (10) @(negedge clk);
    chk("halt_holds", sb.size(), 1);
    chk("halt_busy", busy, 0);
    gop();
    chk("halted_clear", halted, 0);
    drain(0);
    autogo = 1;
    for (int n = 0; n < 60; n++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] k = r < 4 ? KIND_INSTR : r < 6 ? KIND_MEMWR : r < 9 ? KIND_MEMRD : KIND_HALT;
      push(k, k == KIND_INSTR ? ($urandom | 32'h1) : 32'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(1);
    autogo = 0;
    push(KIND_MEMRD, 4, 0, 0, 0);
    for (int i = 0; i < 100 && !rdl; i++) @(negedge clk);
    chk("rd_wait_reached", rdl, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_core", {opcode, oprand1, oprand2, oprand3, addr, data, wl, rdl}, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_busy", {busy, rd_valid}, 0);
    chk("arst_issue_count", issue_count, 0);
    sb.delete();
    rdq.delete();
    rd_cyc.delete();
    model_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      chk("arst_no_rd_valid", rd_valid, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
